// File: rtl/iomem_gpio.sv
// GPIO peripheral for the PicoSoC iomem bus: OUT/OE/IN registers plus optional
// edge-triggered interrupts with sticky W1C status, enabled by IOMEM_GPIO_IRQ_EN.
module iomem_gpio #(
    parameter int         WIDTH       = 8,
    parameter logic [7:0] BASE_ADDR   = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic                              sel;
    logic [2:0]                        idx;
    logic [WIDTH-1:0]                  wmask;
    logic [WIDTH-1:0]                  wdata_w;
    logic [WIDTH-1:0]                  out_reg;
    logic [WIDTH-1:0]                  oe_reg;
    logic [WIDTH-1:0]                  s;
    logic [WIDTH-1:0]                  rd_bits;
    logic [31:0]                       rd_val;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
    logic                              unused_bits;

    assign sel         = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
    assign idx         = iomem_addr[4:2];
    assign wdata_w     = iomem_wdata[WIDTH-1:0];
    assign s           = sync_chain[SYNC_STAGES-1];
    assign gpio_out    = out_reg;
    assign gpio_oe     = oe_reg;
    assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, iomem_wstrb};

    // Expand byte strobes to a per-bit mask covering only the stored bits.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wmask[i] = iomem_wstrb[i/8];
        end
    end

`ifdef IOMEM_GPIO_IRQ_EN
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_rise;
    logic [WIDTH-1:0] irq_status;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] clear_mask;

    assign edge_event = irq_en & ((irq_rise & s & ~p) | (~irq_rise & ~s & p));
    assign clear_mask = (sel && idx == 3'd5) ? (wdata_w & wmask) : '0;
    assign irq        = |irq_status;

    // A new event wins over a simultaneous clear of the same bit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq_en     <= '0;
            irq_rise   <= '0;
            irq_status <= '0;
            p          <= '0;
        end else begin
            p          <= s;
            irq_status <= (irq_status & ~clear_mask) | edge_event;
            if (sel && idx == 3'd3) irq_en   <= (irq_en & ~wmask) | (wdata_w & wmask);
            if (sel && idx == 3'd4) irq_rise <= (irq_rise & ~wmask) | (wdata_w & wmask);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_bits = '0;
        case (idx)
            3'd0: rd_bits = out_reg;
            3'd1: rd_bits = oe_reg;
            3'd2: rd_bits = s;
`ifdef IOMEM_GPIO_IRQ_EN
            3'd3: rd_bits = irq_en;
            3'd4: rd_bits = irq_rise;
            3'd5: rd_bits = irq_status;
`endif
            default: rd_bits = '0;
        endcase
        rd_val = '0;
        rd_val[WIDTH-1:0] = rd_bits;
    end

    // Read data is captured in the select cycle, so a combined access returns the pre-write value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            out_reg     <= '0;
            oe_reg      <= '0;
        end else begin
            iomem_ready <= sel;
            iomem_rdata <= sel ? rd_val : '0;
            if (sel && idx == 3'd0) out_reg <= (out_reg & ~wmask) | (wdata_w & wmask);
            if (sel && idx == 3'd1) oe_reg  <= (oe_reg & ~wmask) | (wdata_w & wmask);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], gpio_in};
        end
    end

endmodule

// File: tb/tb_iomem_gpio.sv
// Directed self-checking bench for iomem_gpio (WIDTH=8, SYNC_STAGES=2); the IRQ
// checks follow whichever build of IOMEM_GPIO_IRQ_EN the design was compiled with.
module tb_iomem_gpio;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             resetn;
    logic             iomem_valid;
    logic             iomem_ready;
    logic [3:0]       iomem_wstrb;
    logic [31:0]      iomem_addr;
    logic [31:0]      iomem_wdata;
    logic [31:0]      iomem_rdata;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic [31:0] out_snap;
    logic        rdy;
    logic        irq_snap;

    iomem_gpio #(
        .WIDTH(WIDTH),
        .BASE_ADDR(8'h03),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .gpio_in(gpio_in),
        .gpio_out(gpio_out),
        .gpio_oe(gpio_oe),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One bus access: select edge, then ready edge; results are sampled just after the ready edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                                 output logic [31:0] rdata, output logic ready_seen,
                                 output logic [31:0] out_seen, output logic irq_seen);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = data;
        @(posedge clk);
        #1;
        ready_seen  = iomem_ready;
        rdata       = iomem_rdata;
        out_seen    = {24'h0, gpio_out};
        irq_seen    = irq;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        gpio_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'h0, iomem_ready}, 32'h0);
        checkOutput("reset_rdata", iomem_rdata, 32'h0);
        checkOutput("reset_out", {24'h0, gpio_out}, 32'h0);
        checkOutput("reset_oe", {24'h0, gpio_oe}, 32'h0);
        checkOutput("reset_irq", {31'h0, irq}, 32'h0);

        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        iomem_wstrb = 4'b0001;
        iomem_wdata = 32'h0000_00FF;
        resetn      = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset_ready", {31'h0, iomem_ready}, 32'h0);
        checkOutput("midreset_out", {24'h0, gpio_out}, 32'h0);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        resetn      = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_ready_after", {31'h0, iomem_ready}, 32'h0);
        checkOutput("midreset_out_after", {24'h0, gpio_out}, 32'h0);

        applyStimulus(32'h0300_0000, 4'b0001, 32'h0000_00A5, rd, rdy, out_snap, irq_snap);
        checkOutput("out_wr_ready", {31'h0, rdy}, 32'h1);
        checkOutput("out_wr_gpio", out_snap, 32'h0000_00A5);
        checkOutput("out_wr_prewrite_rdata", rd, 32'h0);
        checkOutput("out_wr_ready_drop", {31'h0, iomem_ready}, 32'h0);

        applyStimulus(32'h0300_0000, 4'b1110, 32'hFFFF_FF00, rd, rdy, out_snap, irq_snap);
        checkOutput("out_upper_strb_gpio", out_snap, 32'h0000_00A5);
        checkOutput("out_upper_strb_rdata", rd, 32'h0000_00A5);
        applyStimulus(32'h0300_0000, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("out_read", rd, 32'h0000_00A5);

        applyStimulus(32'h0300_0004, 4'b1111, 32'h0000_5A5A, rd, rdy, out_snap, irq_snap);
        checkOutput("oe_wr_gpio", {24'h0, gpio_oe}, 32'h0000_005A);
        applyStimulus(32'h03FF_FFE7, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("oe_read_alias", rd, 32'h0000_005A);

        // IN sampled at the select edge of the first read is still the old value.
        @(negedge clk);
        gpio_in = 8'h3C;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0008;
        iomem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        checkOutput("in_read_early", iomem_rdata, 32'h0);
        iomem_valid = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(32'h0300_0008, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("in_read_synced", rd, 32'h0000_003C);

        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0008;
        iomem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        checkOutput("unsel_ready_1", {31'h0, iomem_ready}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("unsel_ready_2", {31'h0, iomem_ready}, 32'h0);
        iomem_valid = 1'b0;

        applyStimulus(32'h0300_0018, 4'b1111, 32'hFFFF_FFFF, rd, rdy, out_snap, irq_snap);
        applyStimulus(32'h0300_0018, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("reg6_read", rd, 32'h0);
        applyStimulus(32'h0300_001C, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("reg7_ready", {31'h0, rdy}, 32'h1);
        checkOutput("reg7_read", rd, 32'h0);

        applyStimulus(32'h0300_0000, 4'b1111, 32'hFFFF_FFFF, rd, rdy, out_snap, irq_snap);
        checkOutput("out_full_gpio", out_snap, 32'h0000_00FF);
        applyStimulus(32'h0300_0000, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("out_full_read", rd, 32'h0000_00FF);

`ifdef IOMEM_GPIO_IRQ_EN
        applyStimulus(32'h0300_000C, 4'b1111, 32'h0000_0001, rd, rdy, out_snap, irq_snap);
        applyStimulus(32'h0300_0010, 4'b1111, 32'h0000_0001, rd, rdy, out_snap, irq_snap);
        applyStimulus(32'h0300_000C, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("irq_en_read", rd, 32'h0000_0001);
        @(negedge clk);
        gpio_in = 8'h3D;
        @(posedge clk);
        #1;
        checkOutput("rise_irq_k", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rise_irq_k1", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rise_irq_k2", {31'h0, irq}, 32'h1);
        applyStimulus(32'h0300_0014, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("rise_status", rd, 32'h0000_0001);
        applyStimulus(32'h0300_0014, 4'b0001, 32'h0000_0001, rd, rdy, out_snap, irq_snap);
        checkOutput("w1c_irq_at_ready", {31'h0, irq_snap}, 32'h0);
        @(negedge clk);
        gpio_in = 8'h3C;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("fall_in_rise_mode_irq", {31'h0, irq}, 32'h0);
        applyStimulus(32'h0300_0014, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("fall_in_rise_mode_status", rd, 32'h0);

        applyStimulus(32'h0300_000C, 4'b0001, 32'h0000_0009, rd, rdy, out_snap, irq_snap);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("enable_stable_level_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        gpio_in = 8'h34;
        @(posedge clk);
        @(posedge clk);
        applyStimulus(32'h0300_0014, 4'b0001, 32'h0000_0008, rd, rdy, out_snap, irq_snap);
        checkOutput("event_beats_clear_irq", {31'h0, irq_snap}, 32'h1);
        applyStimulus(32'h0300_0014, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("event_beats_clear_status", rd, 32'h0000_0008);
        applyStimulus(32'h0300_0014, 4'b0001, 32'h0000_0008, rd, rdy, out_snap, irq_snap);
        checkOutput("fall_clear_irq", {31'h0, irq_snap}, 32'h0);
`else
        applyStimulus(32'h0300_000C, 4'b0001, 32'h0000_00FF, rd, rdy, out_snap, irq_snap);
        applyStimulus(32'h0300_0010, 4'b0001, 32'h0000_00FF, rd, rdy, out_snap, irq_snap);
        @(negedge clk);
        gpio_in = 8'hC3;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("noirq_irq_rise", {31'h0, irq}, 32'h0);
        @(negedge clk);
        gpio_in = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("noirq_irq_fall", {31'h0, irq}, 32'h0);
        applyStimulus(32'h0300_000C, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("noirq_reg3_read", rd, 32'h0);
        applyStimulus(32'h0300_0010, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("noirq_reg4_read", rd, 32'h0);
        applyStimulus(32'h0300_0014, 4'b0000, 32'h0, rd, rdy, out_snap, irq_snap);
        checkOutput("noirq_reg5_read", rd, 32'h0);
`endif

        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("final_reset_out", {24'h0, gpio_out}, 32'h0);
        checkOutput("final_reset_oe", {24'h0, gpio_oe}, 32'h0);
        checkOutput("final_reset_irq", {31'h0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iomem_gpio.md
# iomem_gpio

Parametrised GPIO peripheral for the PicoSoC iomem bus: up to 32 bidirectional channels with per-bit output-enable, synchronised inputs, and per-bit edge-triggered interrupts with sticky write-1-to-clear status. It replaces the fixed 8-bit output-only LED register in board tops. It sits between the `picosoc` iomem port and the board `SB_IO` pads, with `irq` driven into one of `irq_5`..`irq_7`.

## Interface
- `WIDTH`, 8: number of GPIO channels, 1..32.
- `BASE_ADDR`, 8'h03: value matched against `iomem_addr[31:24]`.
- `SYNC_STAGES`, 2: input synchroniser depth, ≥2.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset; synchronous, active-low.
- `iomem_valid`  in  1  request valid.
- `iomem_ready`  out  1  one-cycle acknowledge.
- `iomem_wstrb`  in  4  byte write strobes; 0 means read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data; valid while `iomem_ready`=1.
- `gpio_in`  in  WIDTH  asynchronous pad inputs.
- `gpio_out`  out  WIDTH  pad output values (OUT register).
- `gpio_oe`  out  WIDTH  pad output enables (OE register).
- `irq`  out  1  level interrupt; equals OR of IRQ_STATUS.

## Operation
- Select: `iomem_valid & !iomem_ready & iomem_addr[31:24]==BASE_ADDR`. Register index is `iomem_addr[4:2]`; `iomem_addr[23:5]` and `[1:0]` are ignored.
- Register map:
  - 0 OUT: rw.
  - 1 OE: rw.
  - 2 IN: ro, synchronised pad value.
  - 3 IRQ_EN: rw.
  - 4 IRQ_RISE: rw; 1 = rising edge, 0 = falling edge.
  - 5 IRQ_STATUS: read; write-1-to-clear.
  - 6, 7: read 0; writes ignored.
- Writes are byte-granular per `iomem_wstrb`. Bits ≥WIDTH are not stored and read 0.
- The read value is sampled in the select cycle. For a combined read/write, the read returns the pre-write value.
- Synchroniser: a SYNC_STAGES flop chain gives `s`; `p` holds `s` delayed one cycle.
- Edge event for bit i: `IRQ_EN[i] & (IRQ_RISE[i] ? s[i]&!p[i] : !s[i]&p[i])`.
- Status update: `IRQ_STATUS <= (IRQ_STATUS & ~clear_mask) | event`. When an event and a clear of the same bit occur in the same cycle, the bit stays set.
- Clearing IRQ_EN does not clear pending status. Setting IRQ_EN never raises an event for a level that is already stable.
- Unselected requests (other address) leave `iomem_ready` low; another slave answers them.

## Timing
- Reset values: all registers, synchroniser flops, `p`, `iomem_ready`, `iomem_rdata`, `gpio_out`, `gpio_oe` and `irq` are 0.
- Access latency: `iomem_ready`=1 exactly one cycle after the select cycle, then 0 the next cycle. Back-to-back accesses therefore take 2 cycles each.
- `gpio_out` and `gpio_oe` change on the same edge that raises `iomem_ready`.
- An input transition sampled at edge k:
  - visible in IN at edge k+SYNC_STAGES-1;
  - sets IRQ_STATUS and `irq` at edge k+SYNC_STAGES.
- `irq` is combinational from the IRQ_STATUS flops, with no extra delay.
- A W1C clear drops `irq` on the ready edge, unless a new event lands on the same edge.
- Reset mid-transaction: `iomem_ready` is 0 the cycle after `resetn` is sampled low, and the write is discarded. The host must reissue the access.

## Configuration
- `IOMEM_GPIO_IRQ_EN` defined: IRQ_EN, IRQ_RISE, IRQ_STATUS and edge logic are present, and `irq` behaves as above.
- Not defined: registers 3–5 read 0 and ignore writes, `p` and the edge logic are removed, and `irq` is tied 0. The IN register and synchroniser remain.

## Test plan
- Write OUT=0x000000A5 with wstrb=4'b0001, WIDTH=8 → `gpio_out`=0xA5 on the ready edge; read index 0 returns 0xA5. Write 0xFFFF_FF00 with wstrb=4'b1110 → OUT still 0xA5.
- Idle reset check → every output is 0. Assert `resetn`=0 in a select cycle → `iomem_ready` stays 0 and OUT stays 0.
- Drive `gpio_in`=0x3C with SYNC_STAGES=2 → read of IN returns 0x3C once 2 edges have elapsed, 0 before. Address 0x04000008 → no `iomem_ready`.
- IRQ_EN=0x01, IRQ_RISE=0x01; `gpio_in[0]` goes 0→1 → IRQ_STATUS=0x01 and `irq`=1 two edges later. Write 0x01 to index 5 → `irq`=0. The 1→0 edge sets nothing.
- Falling-edge mode on bit 3, with the edge arriving in the same cycle as a W1C of bit 3 → status bit 3 remains 1.
- Build without `IOMEM_GPIO_IRQ_EN`: write 0xFF to index 3, toggle inputs → read of index 3 returns 0 and `irq` stays 0.
